// File: rtl/rsp_s2_dma_ahbic_decp.sv
// AHB bus-switch output-port decoder: address decode to one-hot HSEL, data-phase
// response mux, and a built-in default slave that logs accesses to unmapped addresses.
module rsp_s2_dma_ahbic_decp #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 32,
  parameter int ADDR_LSB  = 10,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_BASE =
    (NUM_PORTS*(32-ADDR_LSB))'({(32-ADDR_LSB)'(7), (32-ADDR_LSB)'(6), (32-ADDR_LSB)'(5),
                                (32-ADDR_LSB)'(4), (32-ADDR_LSB)'(3), (32-ADDR_LSB)'(2),
                                (32-ADDR_LSB)'(1), (32-ADDR_LSB)'(0)}),
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_MASK = '1
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HREADYS,
  input  logic                        sel_dec,
  input  logic [31-ADDR_LSB:0]        decode_addr_dec,
  input  logic [1:0]                  trans_dec,
  input  logic [NUM_PORTS-1:0]        active_dec_i,
  input  logic [NUM_PORTS-1:0]        readyout_dec_i,
  input  logic [2*NUM_PORTS-1:0]      resp_dec_i,
  input  logic [DATA_W*NUM_PORTS-1:0] rdata_dec_i,
  input  logic                        err_clr,
  output logic [NUM_PORTS-1:0]        sel_dec_o,
  output logic                        active_dec,
  output logic                        HREADYOUTS,
  output logic [1:0]                  HRESPS,
  output logic [DATA_W-1:0]           HRDATAS,
  output logic [15:0]                 err_cnt,
  output logic [31:0]                 err_addr,
  output logic [1:0]                  dbg_state
);

  localparam int DW = 32 - ADDR_LSB;
  localparam int PW = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0] DEF_PORT = PW'(NUM_PORTS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   addr_port, data_port, hit_idx;
  logic            hit, err_start, def_ready;
  logic [1:0]      def_resp;
  logic [15:0]     err_cnt_q;
  logic [31:0]     err_addr_q;

  // Descending scan so the lowest matching port index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((decode_addr_dec & REGION_MASK[i*DW +: DW]) ==
          (REGION_BASE[i*DW +: DW] & REGION_MASK[i*DW +: DW])) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
    if (hit)                    addr_port = hit_idx;
    else if (trans_dec == 2'b00) addr_port = data_port;
    else                         addr_port = DEF_PORT;
  end

  always_comb begin
    sel_dec_o  = '0;
    active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        sel_dec_o[i] = sel_dec;
        active_dec   = active_dec_i[i];
      end
    end
  end

  // Handshake: an address phase is accepted, and data_port advances, only on an
  // HCLK edge with HREADYS=1; while HREADYS=0 the current data phase is extended.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) data_port <= '0;
    else if (HREADYS) data_port <= addr_port;
  end

  always_comb begin
    HREADYOUTS = def_ready;
    HRESPS     = def_resp;
    HRDATAS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PW'(i)) begin
        HREADYOUTS = readyout_dec_i[i];
        HRESPS     = resp_dec_i[2*i +: 2];
        HRDATAS    = rdata_dec_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Default slave: two-cycle ERROR response for NONSEQ/SEQ to unmapped space.
  assign err_start = sel_dec && (addr_port == DEF_PORT) && HREADYS && trans_dec[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    def_ready  = 1'b1;
    def_resp   = 2'b00;
    case (state)
      ST_IDLE: if (err_start) next_state = ST_ERR1;
      ST_ERR1: begin
        def_ready  = 1'b0;
        def_resp   = 2'b01;
        next_state = ST_ERR2;
      end
      ST_ERR2: begin
        def_resp   = 2'b01;
        next_state = err_start ? ST_ERR1 : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A clear coinciding with a new error leaves exactly that one error logged.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (err_clr) begin
      err_cnt_q  <= (next_state == ST_ERR1) ? 16'd1 : 16'd0;
      err_addr_q <= (next_state == ST_ERR1) ? {decode_addr_dec, {ADDR_LSB{1'b0}}} : 32'd0;
    end else if (next_state == ST_ERR1) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      err_addr_q <= {decode_addr_dec, {ADDR_LSB{1'b0}}};
    end
  end

  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_decp.sv
// Directed bench for rsp_s2_dma_ahbic_decp: decode, hold, default-slave errors,
// error log clear/saturation and reset behaviour.
module tb_rsp_s2_dma_ahbic_decp;

  localparam int NP = 5;
  localparam int DW = 22;
  localparam logic [NP*DW-1:0] TB_MASK = {{DW{1'b1}}, ~22'h2, {(3*DW){1'b1}}};
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HREADYS, sel_dec, err_clr;
  logic [DW-1:0]     decode_addr_dec;
  logic [1:0]        trans_dec;
  logic [NP-1:0]     active_dec_i, readyout_dec_i;
  logic [2*NP-1:0]   resp_dec_i;
  logic [32*NP-1:0]  rdata_dec_i;
  logic [NP-1:0]     sel_dec_o;
  logic              active_dec, HREADYOUTS;
  logic [1:0]        HRESPS, dbg_state;
  logic [31:0]       HRDATAS, err_addr;
  logic [15:0]       err_cnt;

  int checks   = 0;
  int failures = 0;

  rsp_s2_dma_ahbic_decp #(
    .NUM_PORTS(NP), .DATA_W(32), .ADDR_LSB(10), .REGION_MASK(TB_MASK)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec),
    .active_dec_i(active_dec_i), .readyout_dec_i(readyout_dec_i),
    .resp_dec_i(resp_dec_i), .rdata_dec_i(rdata_dec_i), .err_clr(err_clr),
    .sel_dec_o(sel_dec_o), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .err_cnt(err_cnt), .err_addr(err_addr),
    .dbg_state(dbg_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [DW-1:0] a, input logic [1:0] t,
                       input logic hr, input logic clr);
    @(negedge HCLK);
    sel_dec = s; decode_addr_dec = a; trans_dec = t; HREADYS = hr; err_clr = clr;
    #1;
  endtask

  initial begin
    HRESET = 1'b1; HREADYS = 1'b1; sel_dec = 1'b0; err_clr = 1'b0;
    decode_addr_dec = '0; trans_dec = T_IDLE;
    active_dec_i = 5'b10110; readyout_dec_i = '1; resp_dec_i = '0;
    for (int i = 0; i < NP; i++) rdata_dec_i[i*32 +: 32] = 32'hA000_0000 + 32'(i);

    repeat (2) @(posedge HCLK);
    @(negedge HCLK); #1;
    check_eq("rst_rdata", HRDATAS, 32'hA000_0000);
    check_eq("rst_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("rst_resp", 32'(HRESPS), 32'd0);
    check_eq("rst_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_eaddr", err_addr, 32'd0);
    check_eq("rst_sel", 32'(sel_dec_o), 32'd0);
    @(negedge HCLK); HRESET = 1'b0;

    // mapped access to port 3
    drive(1'b1, 22'h3, T_NONSEQ, 1'b1, 1'b0);
    check_eq("p3_sel", 32'(sel_dec_o), 32'b01000);
    check_eq("p3_active", 32'(active_dec), 32'd0);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("p3_rdata", HRDATAS, 32'hA000_0003);

    // unmapped access -> two-cycle error
    drive(1'b1, 22'h8, T_NONSEQ, 1'b1, 1'b0);
    check_eq("um_sel", 32'(sel_dec_o), 32'd0);
    check_eq("um_active", 32'(active_dec), 32'd1);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("err1_ready", 32'(HREADYOUTS), 32'd0);
    check_eq("err1_resp", 32'(HRESPS), 32'd1);
    check_eq("err1_rdata", HRDATAS, 32'd0);
    check_eq("err1_cnt", 32'(err_cnt), 32'd1);
    check_eq("err1_addr", err_addr, 32'h0000_2000);
    drive(1'b0, 22'h8, T_IDLE, 1'b1, 1'b0);
    check_eq("err2_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("err2_resp", 32'(HRESPS), 32'd1);

    // back-to-back errors
    drive(1'b1, 22'h9, T_NONSEQ, 1'b1, 1'b0);
    check_eq("idle_def_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("idle_def_resp", 32'(HRESPS), 32'd0);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("e2_ready", 32'(HREADYOUTS), 32'd0);
    check_eq("e2_cnt", 32'(err_cnt), 32'd2);
    check_eq("e2_addr", err_addr, 32'h0000_2400);
    drive(1'b1, 22'hA, T_NONSEQ, 1'b1, 1'b0);
    check_eq("b2b_err2_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("b2b_err2_resp", 32'(HRESPS), 32'd1);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("b2b_err1_ready", 32'(HREADYOUTS), 32'd0);
    check_eq("b2b_cnt", 32'(err_cnt), 32'd3);
    check_eq("b2b_addr", err_addr, 32'h0000_2800);
    drive(1'b1, 22'h8, T_IDLE, 1'b1, 1'b0);
    check_eq("idle_um_sel", 32'(sel_dec_o), 32'd0);
    drive(1'b1, 22'h8, T_BUSY, 1'b1, 1'b0);
    check_eq("idle_okay_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("idle_okay_resp", 32'(HRESPS), 32'd0);
    check_eq("idle_cnt", 32'(err_cnt), 32'd3);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("busy_okay_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("busy_okay_resp", 32'(HRESPS), 32'd0);
    check_eq("busy_cnt", 32'(err_cnt), 32'd3);

    // overlapping regions: ports 1 and 3 both match 0x400
    drive(1'b1, 22'h1, T_NONSEQ, 1'b1, 1'b0);
    check_eq("ovl_sel", 32'(sel_dec_o), 32'b00010);
    check_eq("ovl_active", 32'(active_dec), 32'd1);
    drive(1'b1, 22'h8, T_IDLE, 1'b1, 1'b0);
    check_eq("hold_sel", 32'(sel_dec_o), 32'b00010);
    check_eq("hold_rdata", HRDATAS, 32'hA000_0001);

    // wait states on port 2
    readyout_dec_i[2] = 1'b0; resp_dec_i[5:4] = 2'b01;
    drive(1'b1, 22'h2, T_NONSEQ, 1'b1, 1'b0);
    check_eq("p2_sel", 32'(sel_dec_o), 32'b00100);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("p2_ready", 32'(HREADYOUTS), 32'd0);
    check_eq("p2_resp", 32'(HRESPS), 32'd1);
    check_eq("p2_rdata", HRDATAS, 32'hA000_0002);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("p2_hold_rdata", HRDATAS, 32'hA000_0002);
    readyout_dec_i[2] = 1'b1; resp_dec_i[5:4] = 2'b00;
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("p2_done_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("p2_done_rdata", HRDATAS, 32'hA000_0002);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("p0_rdata", HRDATAS, 32'hA000_0000);

    // clear concurrent with a new error, then plain clear
    drive(1'b1, 22'h3F, T_NONSEQ, 1'b1, 1'b1);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("clr_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("clr_err_addr", err_addr, 32'h0000_FC00);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b1);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("clr_cnt", 32'(err_cnt), 32'd0);
    check_eq("clr_addr", err_addr, 32'd0);

    // saturation from a preloaded count
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    drive(1'b1, 22'h8, T_NONSEQ, 1'b1, 1'b0);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("sat_cnt_max", 32'(err_cnt), 32'hFFFF);
    drive(1'b1, 22'h8, T_NONSEQ, 1'b1, 1'b0);
    drive(1'b0, 22'h0, T_IDLE, 1'b0, 1'b0);
    check_eq("sat_cnt_hold", 32'(err_cnt), 32'hFFFF);
    check_eq("sat_err1_ready", 32'(HREADYOUTS), 32'd0);

    // reset in the middle of ERR1
    HRESET = 1'b1; #1;
    check_eq("mid_rst_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("mid_rst_resp", 32'(HRESPS), 32'd0);
    check_eq("mid_rst_rdata", HRDATAS, 32'hA000_0000);
    check_eq("mid_rst_cnt", 32'(err_cnt), 32'd0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge HCLK); HRESET = 1'b0; #1;
    check_eq("post_rst_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("post_rst_resp", 32'(HRESPS), 32'd0);
    drive(1'b1, 22'h8, T_BUSY, 1'b1, 1'b0);
    drive(1'b0, 22'h0, T_IDLE, 1'b1, 1'b0);
    check_eq("post_rst_def_ready", 32'(HREADYOUTS), 32'd1);
    check_eq("post_rst_def_resp", 32'(HRESPS), 32'd0);
    check_eq("post_rst_cnt", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsp_s2_dma_ahbic_decp.md
RSP_S2_DMA_AHBIC_DECP -- requirements
Module: rsp_s2_dma_ahbic_decp

Interface (parameters: name, default, meaning)
REQ-001 SHALL have parameter NUM_PORTS, 5, number of bus-switch output ports (1..8).
REQ-002 SHALL have parameter DATA_W, 32, read-data width (32 or 64).
REQ-003 SHALL have parameter ADDR_LSB, 10, lowest decoded address bit; decode width DW = 32-ADDR_LSB.
REQ-004 SHALL have parameter REGION_BASE, flattened NUM_PORTS*DW bits, default port i base = i; per-port region base.
REQ-005 SHALL have parameter REGION_MASK, flattened NUM_PORTS*DW bits, default all ones; per-port compare mask.

Interface (ports: name direction width meaning)
REQ-006 SHALL have HCLK in 1 system clock; HRESET in 1 reset, asynchronous, active-high.
REQ-007 SHALL have HREADYS in 1 transfer done; sel_dec in 1 HSEL; decode_addr_dec in DW address bits [31:ADDR_LSB]; trans_dec in 2 HTRANS.
REQ-008 SHALL have active_dec_i in NUM_PORTS; readyout_dec_i in NUM_PORTS; resp_dec_i in 2*NUM_PORTS; rdata_dec_i in DATA_W*NUM_PORTS (port i at slice i).
REQ-009 SHALL have sel_dec_o out NUM_PORTS one-hot HSEL; active_dec out 1; HREADYOUTS out 1; HRESPS out 2; HRDATAS out DATA_W.
REQ-010 SHALL have err_clr in 1 clears error log; err_cnt out 16 decode-error count; err_addr out 32 last unmapped address {decode_addr_dec, ADDR_LSB zeros}.

Function
REQ-011 Port i SHALL match when (decode_addr_dec & MASK_i) == (BASE_i & MASK_i); lowest matching index wins.
REQ-012 When trans_dec==IDLE and no match, addr_port SHALL hold the current data_port (including default code NUM_PORTS).
REQ-013 No match and no hold SHALL select default port (code NUM_PORTS).
REQ-014 sel_dec_o[i] SHALL be 1 only when sel_dec=1 and addr_port==i; all zero when sel_dec=0.
REQ-015 active_dec SHALL equal active_dec_i[addr_port], or 1 when addr_port is default.
REQ-016 data_port register SHALL load addr_port on every rising HCLK with HREADYS=1, else hold.
REQ-017 HREADYOUTS/HRESPS/HRDATAS SHALL mux from data_port slice; default port drives default-slave ready/resp and HRDATAS=0.
REQ-018 Default slave FSM states IDLE, ERR1, ERR2.
REQ-019 IDLE->ERR1 when sel_dec=1, addr_port=default, HREADYS=1, trans_dec[1]=1 (NONSEQ/SEQ); else stay IDLE.
REQ-020 IDLE: ready=1 resp=OKAY(00); ERR1: ready=0 resp=ERROR(01); ERR2: ready=1 resp=ERROR(01).
REQ-021 ERR1->ERR2 unconditionally; ERR2->ERR1 if REQ-019 entry condition holds again, else ->IDLE.
REQ-022 IDLE/BUSY transfers to default port SHALL complete zero-wait OKAY.
REQ-023 On each FSM entry into ERR1, err_cnt SHALL increment (saturate at 0xFFFF) and err_addr SHALL capture the address.
REQ-024 err_clr=1 SHALL zero err_cnt and err_addr on next edge; simultaneous new error SHALL yield err_cnt=1 and err_addr=new address.
REQ-025 Purely combinational paths: addr decode to sel_dec_o/active_dec, data_port to data-phase outputs; no added latency.

Reset
REQ-026 HRESET=1 SHALL asynchronously set data_port=0, FSM=IDLE, err_cnt=0, err_addr=0.
REQ-027 During reset outputs SHALL follow port 0 data phase; sel_dec_o/active_dec remain combinational.
REQ-028 Reset asserted in ERR1 SHALL abort the error response; first cycle after release shows port 0 data phase.

Verification
REQ-029 Defaults, addr 0x00000C00 NONSEQ, sel_dec=1 -> sel_dec_o=5'b01000; next cycle HRDATAS=rdata slice 3.
REQ-030 Addr 0x00002000 NONSEQ -> sel_dec_o=0; next two cycles HREADYOUTS=0/1, HRESPS=01/01; err_cnt=1, err_addr=0x00002000.
REQ-031 Back-to-back unmapped NONSEQ in ERR2 -> ERR1 again, err_cnt=2; IDLE to unmapped -> zero-wait OKAY, err_cnt unchanged.
REQ-032 Overlapping regions (port 1 and port 3 masks match 0x400) -> only sel_dec_o[1]=1.
REQ-033 Port 2 active, readyout_dec_i[2]=0 with HREADYS=0 -> data_port holds 2 until HREADYS=1; err_clr concurrent with error -> err_cnt=1.
REQ-034 err_cnt preloaded at 0xFFFF plus error -> remains 0xFFFF; HRESET mid-ERR1 -> FSM IDLE, err_cnt=0.
